// File: rtl/mac_pkg.sv
// Shared types and sizing for the MAC operand memory: FSM states and address widths.
package mac_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOAD    = 2'd1,
    ARMED   = 2'd2,
    COMPUTE = 2'd3
  } state_t;

  localparam int DEF_M = 4;
  localparam int DEF_K = 4;
  localparam int DEF_N = 4;

  // Address widths for the default geometry.
  localparam int A_AW = $clog2(DEF_M * DEF_K);
  localparam int B_AW = $clog2(DEF_K * DEF_N);
  localparam int C_AW = $clog2(DEF_M * DEF_N);

  // Never return a zero-width address for a degenerate one-word array.
  function automatic int addr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/mac_sp_ram.sv
// Single-write-port array with a registered read port; storage itself is never reset.
module mac_sp_ram #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8,
  parameter int AW    = 4
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             clr,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Same-address read and write in one cycle returns the pre-write contents.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/mac_operand_memory.sv
// Operand (A, B) and result (C) storage for a matrix MAC with host load/compute/readout FSM.
// Optional: define MAC_OPERAND_MEMORY_CLEAR_C_EN to zero C when compute starts.
module mac_operand_memory
  import mac_pkg::*;
#(
  parameter int param_M            = DEF_M,
  parameter int param_K            = DEF_K,
  parameter int param_N            = DEF_N,
  parameter int DATA_WIDTH_INITIAL = 8,
  parameter int DATA_WIDTH_FINAL   = DATA_WIDTH_INITIAL * 2
) (
  input  logic                                      clk,
  input  logic                                      rstn,
  input  logic                                      ld_valid,
  output logic                                      ld_ready,
  input  logic [DATA_WIDTH_INITIAL-1:0]             ld_data,
  input  logic                                      start,
  output logic                                      busy,
  output logic                                      done,
  output logic                                      mac_start,
  input  logic                                      mac_done,
  input  logic                                      a_b_re,
  input  logic [addr_w(param_M*param_K)-1:0]        a_addr_in,
  input  logic [addr_w(param_K*param_N)-1:0]        b_addr_in,
  output logic [DATA_WIDTH_INITIAL-1:0]             a_data_out,
  output logic [DATA_WIDTH_INITIAL-1:0]             b_data_out,
  input  logic                                      c_we,
  input  logic [addr_w(param_M*param_N)-1:0]        c_addr_in,
  input  logic [DATA_WIDTH_FINAL-1:0]               c_data_in,
  input  logic                                      rd_en,
  input  logic [addr_w(param_M*param_N)-1:0]        rd_addr,
  output logic [DATA_WIDTH_FINAL-1:0]               rd_data,
  output logic                                      rd_valid
);

  localparam int MK    = param_M * param_K;
  localparam int KN    = param_K * param_N;
  localparam int MN    = param_M * param_N;
  localparam int TOTAL = MK + KN;
  localparam int A_W   = addr_w(MK);
  localparam int B_W   = addr_w(KN);
  localparam int C_W   = addr_w(MN);
  localparam int CW    = addr_w(TOTAL + 1);

  state_t        state_reg, state_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic          done_reg;
  logic          rd_valid_reg;

  logic          beat;
  logic          in_a;
  logic [CW-1:0] b_off;
  logic          a_we, b_we, c_we_gated, c_re, c_clr;

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    ld_ready   = 1'b0;
    busy       = 1'b0;
    mac_start  = 1'b0;
    case (state_reg)
      IDLE, LOAD: begin
        ld_ready = 1'b1;
        busy     = (state_reg == LOAD);
        if (ld_valid) begin
          if (cnt_reg == CW'(TOTAL - 1)) begin
            state_next = ARMED;
            cnt_next   = '0;
          end else begin
            state_next = LOAD;
            cnt_next   = cnt_reg + 1'b1;
          end
        end
      end
      ARMED: begin
        if (start) state_next = COMPUTE;
      end
      COMPUTE: begin
        busy      = 1'b1;
        mac_start = 1'b1;
        if (mac_done) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg    <= IDLE;
      cnt_reg      <= '0;
      done_reg     <= 1'b0;
      rd_valid_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      done_reg     <= (state_reg == COMPUTE) && mac_done;
      rd_valid_reg <= rd_en && (state_reg != COMPUTE);
    end
  end

  assign done     = done_reg;
  assign rd_valid = rd_valid_reg;

  // One counter walks A first, then B; the B address is the offset past A.
  assign beat       = ld_valid && ld_ready;
  assign in_a       = cnt_reg < CW'(MK);
  assign b_off      = cnt_reg - CW'(MK);
  assign a_we       = beat && in_a;
  assign b_we       = beat && !in_a;
  assign c_we_gated = c_we && (state_reg == COMPUTE);
  assign c_re       = rd_en && (state_reg != COMPUTE);

`ifdef MAC_OPERAND_MEMORY_CLEAR_C_EN
  assign c_clr = (state_reg == ARMED) && start;
`else
  assign c_clr = 1'b0;
`endif

  mac_sp_ram #(.DEPTH(MK), .WIDTH(DATA_WIDTH_INITIAL), .AW(A_W)) u_a_ram (
    .clk   (clk),
    .rstn  (rstn),
    .we    (a_we),
    .waddr (cnt_reg[A_W-1:0]),
    .wdata (ld_data),
    .clr   (1'b0),
    .re    (a_b_re),
    .raddr (a_addr_in),
    .rdata (a_data_out)
  );

  mac_sp_ram #(.DEPTH(KN), .WIDTH(DATA_WIDTH_INITIAL), .AW(B_W)) u_b_ram (
    .clk   (clk),
    .rstn  (rstn),
    .we    (b_we),
    .waddr (b_off[B_W-1:0]),
    .wdata (ld_data),
    .clr   (1'b0),
    .re    (a_b_re),
    .raddr (b_addr_in),
    .rdata (b_data_out)
  );

  mac_sp_ram #(.DEPTH(MN), .WIDTH(DATA_WIDTH_FINAL), .AW(C_W)) u_c_ram (
    .clk   (clk),
    .rstn  (rstn),
    .we    (c_we_gated),
    .waddr (c_addr_in),
    .wdata (c_data_in),
    .clr   (c_clr),
    .re    (c_re),
    .raddr (rd_addr),
    .rdata (rd_data)
  );

endmodule

// File: tb/tb_mac_operand_memory.sv
// Self-checking bench for mac_operand_memory with a behavioural MAC and a readout scoreboard.
module tb_mac_operand_memory;

  logic        clk = 1'b0;
  logic        rstn;
  logic        ld_valid;
  logic        ld_ready;
  logic [7:0]  ld_data;
  logic        start;
  logic        busy;
  logic        done;
  logic        mac_start;
  logic        mac_done;
  logic        a_b_re;
  logic [3:0]  a_addr_in;
  logic [3:0]  b_addr_in;
  logic [7:0]  a_data_out;
  logic [7:0]  b_data_out;
  logic        c_we;
  logic [3:0]  c_addr_in;
  logic [15:0] c_data_in;
  logic        rd_en;
  logic [3:0]  rd_addr;
  logic [15:0] rd_data;
  logic        rd_valid;

  int errors = 0;
  int checks = 0;
  int a_mem [16];
  int b_mem [16];
  logic [15:0] exp_q [$];

  always #5 clk = ~clk;

  mac_operand_memory dut (
    .clk        (clk),
    .rstn       (rstn),
    .ld_valid   (ld_valid),
    .ld_ready   (ld_ready),
    .ld_data    (ld_data),
    .start      (start),
    .busy       (busy),
    .done       (done),
    .mac_start  (mac_start),
    .mac_done   (mac_done),
    .a_b_re     (a_b_re),
    .a_addr_in  (a_addr_in),
    .b_addr_in  (b_addr_in),
    .a_data_out (a_data_out),
    .b_data_out (b_data_out),
    .c_we       (c_we),
    .c_addr_in  (c_addr_in),
    .c_data_in  (c_data_in),
    .rd_en      (rd_en),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .rd_valid   (rd_valid)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic send_beat(input logic [7:0] d);
    ld_valid = 1'b1;
    ld_data  = d;
    tick();
    ld_valid = 1'b0;
  endtask

  task automatic send_range(input int first, input int last);
    for (int i = first; i < last; i++) begin
      if (i < 16) send_beat(8'(a_mem[i]));
      else        send_beat(8'(b_mem[i-16]));
    end
  endtask

  task automatic pulse_start;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic pulse_mac_done;
    mac_done = 1'b1;
    tick();
    mac_done = 1'b0;
  endtask

  task automatic write_c(input int addr, input logic [15:0] v);
    c_we      = 1'b1;
    c_addr_in = 4'(addr);
    c_data_in = v;
    tick();
    c_we      = 1'b0;
  endtask

  // Reads C[addr] back-to-back, one request per cycle, comparing against the queue.
  task automatic read_c(input int addr, input logic [15:0] expv, input string tag);
    logic [15:0] e;
    rd_en   = 1'b1;
    rd_addr = 4'(addr);
    exp_q.push_back(expv);
    tick();
    rd_en = 1'b0;
    e = exp_q.pop_front();
    checks++;
    if (rd_valid !== 1'b1 || rd_data !== e) begin
      errors++;
      $display("FAIL %s addr=%0d got data=%h valid=%b want data=%h valid=1", tag, addr, rd_data, rd_valid, e);
    end else begin
      $display("read %s addr=%0d data=%h", tag, addr, rd_data);
    end
  endtask

  task automatic test_reset;
    rstn = 1'b0;
    #2;
    checks++;
    if ({ld_ready, busy, done, mac_start, rd_valid} !== 5'b10000 ||
        a_data_out !== 8'h0 || b_data_out !== 8'h0 || rd_data !== 16'h0) begin
      errors++;
      $display("FAIL reset got ld_ready=%b busy=%b done=%b mac_start=%b rd_valid=%b a=%h b=%h rd=%h want 1 0 0 0 0 0 0 0",
               ld_ready, busy, done, mac_start, rd_valid, a_data_out, b_data_out, rd_data);
    end else $display("reset outputs ok");
    tick();
    tick();
    rstn = 1'b1;
    tick();
  endtask

  task automatic test_start_ignored;
    send_range(0, 5);
    pulse_start();
    checks++;
    if (mac_start !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL start_in_load got mac_start=%b busy=%b want 0 1", mac_start, busy);
    end else $display("start during LOAD ignored");
    send_range(5, 32);
    checks++;
    if (ld_ready !== 1'b0 || busy !== 1'b0 || mac_start !== 1'b0) begin
      errors++;
      $display("FAIL armed got ld_ready=%b busy=%b mac_start=%b want 0 0 0", ld_ready, busy, mac_start);
    end else $display("armed after 32 beats");
    send_beat(8'hAA);
    checks++;
    if (ld_ready !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL armed_beat got ld_ready=%b busy=%b want 0 0", ld_ready, busy);
    end else $display("beat in ARMED stays ARMED");
  endtask

  task automatic test_operand_read;
    a_b_re    = 1'b1;
    a_addr_in = 4'd3;
    b_addr_in = 4'd5;
    tick();
    a_b_re = 1'b0;
    checks++;
    if (a_data_out !== 8'(a_mem[3]) || b_data_out !== 8'(b_mem[5])) begin
      errors++;
      $display("FAIL operand_read got a=%h b=%h want a=%h b=%h", a_data_out, b_data_out, 8'(a_mem[3]), 8'(b_mem[5]));
    end else $display("operand read a[3]=%h b[5]=%h", a_data_out, b_data_out);
    a_addr_in = 4'd7;
    tick();
    checks++;
    if (a_data_out !== 8'(a_mem[3])) begin
      errors++;
      $display("FAIL operand_hold got a=%h want %h", a_data_out, 8'(a_mem[3]));
    end else $display("operand held a=%h", a_data_out);
  endtask

  // Behavioural MAC: C[i][j] = sum_k A[i*K+k] * B[j*K+k], via the registered read port.
  task automatic mac_products;
    int sum;
    for (int c = 0; c < 16; c++) begin
      sum = 0;
      for (int k = 0; k < 4; k++) begin
        a_b_re    = 1'b1;
        a_addr_in = 4'((c / 4) * 4 + k);
        b_addr_in = 4'((c % 4) * 4 + k);
        tick();
        sum += int'(a_data_out) * int'(b_data_out);
      end
      a_b_re = 1'b0;
      write_c(c, 16'(sum));
    end
  endtask

  task automatic test_compute;
    int done_cnt;
    pulse_start();
    checks++;
    if (mac_start !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL compute_enter got mac_start=%b busy=%b want 1 1", mac_start, busy);
    end else $display("entered COMPUTE");
    mac_products();
    done_cnt = 0;
    mac_done = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      mac_done = 1'b0;
      if (done === 1'b1) done_cnt++;
      if (i == 0) begin
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || mac_start !== 1'b0) begin
          errors++;
          $display("FAIL done_pulse got done=%b busy=%b mac_start=%b want 1 0 0", done, busy, mac_start);
        end else $display("done asserted after mac_done");
      end
    end
    checks++;
    if (done_cnt != 1) begin
      errors++;
      $display("FAIL done_count got %0d want 1", done_cnt);
    end else $display("done pulsed once");
  endtask

  task automatic test_readout;
    int sum;
    read_c(0, 16'd10, "c0_const");
    read_c(15, 16'd58, "c15_const");
    for (int c = 0; c < 16; c++) begin
      sum = 0;
      for (int k = 0; k < 4; k++) sum += a_mem[(c / 4) * 4 + k] * b_mem[(c % 4) * 4 + k];
      read_c(c, 16'(sum), "c_model");
    end
    tick();
    checks++;
    if (rd_valid !== 1'b0) begin
      errors++;
      $display("FAIL rd_valid_drop got %b want 0", rd_valid);
    end else $display("rd_valid dropped one cycle after rd_en");
  endtask

  task automatic test_compute_isolation;
    logic [15:0] exp_c0;
    send_range(0, 32);
    pulse_start();
    rd_en   = 1'b1;
    rd_addr = 4'd0;
    tick();
    rd_en = 1'b0;
    checks++;
    if (rd_valid !== 1'b0) begin
      errors++;
      $display("FAIL rd_in_compute got rd_valid=%b want 0", rd_valid);
    end else $display("rd_en ignored in COMPUTE");
    ld_valid = 1'b1;
    ld_data  = 8'h63;
    checks++;
    if (ld_ready !== 1'b0) begin
      errors++;
      $display("FAIL ld_in_compute got ld_ready=%b want 0", ld_ready);
    end else $display("ld_ready low in COMPUTE");
    tick();
    ld_valid = 1'b0;
    pulse_mac_done();
    a_b_re    = 1'b1;
    a_addr_in = 4'd0;
    tick();
    a_b_re = 1'b0;
    checks++;
    if (a_data_out !== 8'(a_mem[0])) begin
      errors++;
      $display("FAIL a0_untouched got %h want %h", a_data_out, 8'(a_mem[0]));
    end else $display("A[0] untouched by beat in COMPUTE");
`ifdef MAC_OPERAND_MEMORY_CLEAR_C_EN
    exp_c0 = 16'h0;
`else
    exp_c0 = 16'd10;
`endif
    read_c(0, exp_c0, "c0_after_idle_compute");
  endtask

  task automatic test_load_reset;
    send_range(0, 5);
    rstn = 1'b0;
    #2;
    checks++;
    if (ld_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_load got ld_ready=%b busy=%b want 1 0", ld_ready, busy);
    end else $display("reset mid-LOAD returns to IDLE");
    tick();
    rstn = 1'b1;
    tick();
    send_range(0, 31);
    checks++;
    if (ld_ready !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL reload_31 got ld_ready=%b busy=%b want 1 1", ld_ready, busy);
    end else $display("still loading after 31 beats");
    send_range(31, 32);
    checks++;
    if (ld_ready !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reload_armed got ld_ready=%b busy=%b want 0 0", ld_ready, busy);
    end else $display("reload of 32 beats reaches ARMED");
  endtask

  task automatic test_clear_c;
    logic [15:0] exp_unwritten;
    pulse_start();
    for (int c = 0; c < 16; c++) write_c(c, 16'hFFFF);
    pulse_mac_done();
    send_range(0, 32);
    pulse_start();
    write_c(0, 16'h0005);
    pulse_mac_done();
`ifdef MAC_OPERAND_MEMORY_CLEAR_C_EN
    exp_unwritten = 16'h0000;
`else
    exp_unwritten = 16'hFFFF;
`endif
    read_c(0, 16'h0005, "clr_written");
    read_c(1, exp_unwritten, "clr_unwritten1");
    read_c(15, exp_unwritten, "clr_unwritten15");
  endtask

  initial begin
    ld_valid = 1'b0; ld_data = '0; start = 1'b0; mac_done = 1'b0;
    a_b_re = 1'b0; a_addr_in = '0; b_addr_in = '0;
    c_we = 1'b0; c_addr_in = '0; c_data_in = '0; rd_en = 1'b0; rd_addr = '0;
    for (int i = 0; i < 16; i++) begin
      a_mem[i] = i + 1;
      b_mem[i] = 1;
    end
    test_reset();
    test_start_ignored();
    test_operand_read();
    test_compute();
    test_readout();
    test_compute_isolation();
    test_load_reset();
    test_clear_c();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
